sudoku_checker: RTL and testbench

Solution checker for the Sudoku game, downstream of `main_FSM`. It consumes the one-cycle `check_flag` request and scans the 81-cell board through a read port: 9 rows, then 9 columns, then 9 boxes. It returns `solved` to `main_FSM`'s `solved` input, plus a `done` pulse and the index of the first offending cell.

---
 rtl/sudoku_pkg.sv | 32 +++
 rtl/sudoku_group_addr.sv | 50 +++++
 rtl/sudoku_checker.sv | 135 +++++++++++++
 tb/tb_sudoku_checker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_pkg
// Description : Shared constants and checker state encoding for the Sudoku
//               solution checker and its group address decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package sudoku_pkg;

    localparam int N       = 9;
    localparam int NCELLS  = 81;
    localparam int NGROUPS = 27;
    localparam int CELL_W  = 4;
    localparam int ADDR_W  = 7;

    // Widths of the group (0..26) and in-group position (0..8) counters
    localparam int GW = 5;
    localparam int KW = 4;

    localparam int ROW_G0 = 0;
    localparam int COL_G0 = 9;
    localparam int BOX_G0 = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sudoku_group_addr.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_group_addr
// Description : Maps (group g, position k) to a board cell index: rows 0..8,
//               columns 9..17, 3x3 boxes 18..26.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_group_addr #(
    parameter int ADDR_W = 7
) (
    input  logic [sudoku_pkg::GW-1:0] g,
    input  logic [sudoku_pkg::KW-1:0] k,
    output logic [ADDR_W-1:0]         addr
);
    import sudoku_pkg::*;

    localparam logic [ADDR_W-1:0] C_N   = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] C_3   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] C_ROW = ADDR_W'(ROW_G0);
    localparam logic [ADDR_W-1:0] C_COL = ADDR_W'(COL_G0);
    localparam logic [ADDR_W-1:0] C_BOX = ADDR_W'(BOX_G0);

    logic [ADDR_W-1:0] w_g;
    logic [ADDR_W-1:0] w_k;
    logic [ADDR_W-1:0] w_b;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;

    always_comb begin
        w_g   = ADDR_W'(g);
        w_k   = ADDR_W'(k);
        w_b   = '0;
        w_row = '0;
        w_col = '0;
        if (w_g < C_COL) begin
            w_row = w_g - C_ROW;
            w_col = w_k;
        end else if (w_g < C_BOX) begin
            w_row = w_k;
            w_col = w_g - C_COL;
        end else begin
            w_b   = w_g - C_BOX;
            w_row = (w_b / C_3) * C_3 + w_k / C_3;
            w_col = (w_b % C_3) * C_3 + w_k % C_3;
        end
        addr = w_row * C_N + w_col;
    end

endmodule
`default_nettype wire

// File: rtl/sudoku_checker.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_checker
// Description : Scans all 27 groups of a 9x9 board through a read port and
//               reports whether the board is solved, or the first bad cell.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_checker #(
    parameter int CELL_W = 4,
    parameter int ADDR_W = 7
) (
    input  logic              clka,
    input  logic              restart,
    input  logic              check_flag,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              solved,
    output logic [ADDR_W-1:0] err_cell
);
    import sudoku_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [GW-1:0]     r_g;
    logic [KW-1:0]     r_k;
    logic              r_vld;
    logic              r_first;
    logic [ADDR_W-1:0] r_addr_d;
    logic [N-1:0]      r_seen;
    logic [N-1:0]      w_base;
    logic [N-1:0]      w_hit;
    logic              w_bad;
    logic              w_fail;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    sudoku_group_addr #(
        .ADDR_W (ADDR_W)
    ) u_group_addr (
        .g    (r_g),
        .k    (r_k),
        .addr (w_addr)
    );

    assign w_last = (r_g == GW'(NGROUPS - 1)) && (r_k == KW'(N - 1));

    // Evaluation of the datum returned for the read issued last cycle
    always_comb begin
        w_base = r_first ? '0 : r_seen;
        for (int i = 0; i < N; i++) begin
            w_hit[i] = (rd_data == CELL_W'(i + 1));
        end
        w_bad  = (rd_data == '0) || (rd_data > CELL_W'(N)) || ((w_hit & w_base) != '0);
        w_fail = r_vld && w_bad;
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (check_flag) w_next = ST_READ;
            ST_READ: begin
                if (w_fail) begin
                    w_next = ST_DONE;
                end else if (w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (r_state == ST_READ);
        rd_addr = rd_en ? w_addr : '0;
        busy    = (r_state == ST_READ) || (r_state == ST_DRAIN);
        done    = (r_state == ST_DONE);
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            r_g      <= '0;
            r_k      <= '0;
            r_vld    <= 1'b0;
            r_first  <= 1'b0;
            r_addr_d <= '0;
            r_seen   <= '0;
            solved   <= 1'b0;
            err_cell <= '0;
        end else begin
            if ((r_state == ST_IDLE) && check_flag) begin
                solved   <= 1'b0;
                err_cell <= '0;
                r_g      <= '0;
                r_k      <= '0;
            end
            // A read issued alongside a failing evaluation is never marked valid
            r_vld <= (r_state == ST_READ) && !w_fail;
            if (r_state == ST_READ) begin
                r_addr_d <= w_addr;
                r_first  <= (r_k == '0);
                if (r_k == KW'(N - 1)) begin
                    r_k <= '0;
                    r_g <= r_g + 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
            if (r_vld) begin
                r_seen <= w_base | w_hit;
            end
            if (w_fail) begin
                solved   <= 1'b0;
                err_cell <= r_addr_d;
            end else if (r_state == ST_DRAIN) begin
                solved   <= 1'b1;
                err_cell <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sudoku_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sudoku_checker
// Description : Scoreboard bench for sudoku_checker with a one-cycle board model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sudoku_checker;

    typedef struct {
        int done_cyc;
        int solved;
        int err;
        int reads;
    } exp_t;

    logic       clk = 1'b0;
    logic       restart = 1'b1;
    logic       check_flag = 1'b0;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [3:0] rd_data = 4'd0;
    logic       busy;
    logic       done;
    logic       solved;
    logic [6:0] err_cell;

    logic [3:0] board [0:127];
    int         ref_addr [0:242];
    exp_t       sb [$];
    int         n_cmp = 0;
    int         n_err = 0;

    sudoku_checker #(
        .CELL_W (4),
        .ADDR_W (7)
    ) dut (
        .clka       (clk),
        .restart    (restart),
        .check_flag (check_flag),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .solved     (solved),
        .err_cell   (err_cell)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= board[rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_base();
        for (int i = 0; i < 128; i++) board[i] = 4'd0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r * 9 + c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
    endtask

    // Starts a scan at the current negedge (cycle 0) and watches it to the end.
    task automatic run_scan(input int exp_done, input int exp_solved, input int exp_err,
                            input int exp_reads, input int rst_at,
                            input int flag_a, input int flag_b);
        int   cyc;
        int   reads;
        int   dones;
        int   busy_bad;
        int   stop_at;
        exp_t e;
        cyc      = 0;
        reads    = 0;
        dones    = 0;
        busy_bad = 0;
        stop_at  = 400;
        e.done_cyc = exp_done;
        e.solved   = exp_solved;
        e.err      = exp_err;
        e.reads    = exp_reads;
        sb.push_back(e);
        check_flag = 1'b1;
        while (cyc < stop_at) begin
            @(negedge clk);
            cyc++;
            if (rd_en) begin
                if (reads < 243) check_eq("rd_addr", 32'(rd_addr), 32'(ref_addr[reads]));
                reads++;
            end
            if (rst_at == 0 && busy !== ((cyc < exp_done) ? 1'b1 : 1'b0)) busy_bad++;
            if (done) begin
                dones++;
                if (rst_at == 0 && dones == 1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check_eq("solved", 32'(solved), 32'(e.solved));
                    check_eq("err_cell", 32'(err_cell), 32'(e.err));
                    stop_at = cyc + 4;
                end
            end
            if (rst_at != 0 && cyc == rst_at + 1) begin
                check_eq("rst_rd_en", 32'(rd_en), 0);
                check_eq("rst_rd_addr", 32'(rd_addr), 0);
                check_eq("rst_busy", 32'(busy), 0);
                check_eq("rst_done", 32'(done), 0);
                check_eq("rst_solved", 32'(solved), 0);
                check_eq("rst_err_cell", 32'(err_cell), 0);
                if (sb.size() > 0) e = sb.pop_front();
                stop_at = cyc + 3;
            end
            check_flag = (cyc == flag_a || cyc == flag_b);
            restart    = (rst_at != 0 && cyc == rst_at);
        end
        check_flag = 1'b0;
        restart    = 1'b0;
        if (rst_at == 0) begin
            check_eq("done_count", 32'(dones), 1);
            check_eq("read_count", 32'(reads), 32'(exp_reads));
            check_eq("busy_profile", 32'(busy_bad), 0);
            check_eq("solved_hold", 32'(solved), 32'(exp_solved));
            check_eq("err_cell_hold", 32'(err_cell), 32'(exp_err));
        end else begin
            check_eq("abort_no_done", 32'(dones), 0);
        end
        while (sb.size() > 0) e = sb.pop_front();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        n = 0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin ref_addr[n] = r * 9 + c; n++; end
        for (int c = 0; c < 9; c++)
            for (int r = 0; r < 9; r++) begin ref_addr[n] = r * 9 + c; n++; end
        for (int br = 0; br < 3; br++)
            for (int bc = 0; bc < 3; bc++)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        ref_addr[n] = (br * 3 + i) * 9 + bc * 3 + j;
                        n++;
                    end
        load_base();

        repeat (3) @(negedge clk);
        restart = 1'b0;
        check_eq("reset_rd_en", 32'(rd_en), 0);
        check_eq("reset_rd_addr", 32'(rd_addr), 0);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_done", 32'(done), 0);
        check_eq("reset_solved", 32'(solved), 0);
        check_eq("reset_err_cell", 32'(err_cell), 0);
        @(negedge clk);

        // Legal board, with ignored start pulses mid-scan and during DONE
        run_scan(245, 1, 0, 243, 0, 50, 245);

        load_base();
        board[40] = 4'd0;
        run_scan(43, 0, 40, 42, 0, 0, 0);

        load_base();
        board[0] = 4'd2;
        board[1] = 4'd1;
        run_scan(87, 0, 27, 86, 0, 0, 0);

        load_base();
        board[5] = 4'd12;
        run_scan(8, 0, 5, 7, 0, 0, 0);

        load_base();
        run_scan(0, 0, 0, 0, 100, 0, 0);
        run_scan(245, 1, 0, 243, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
